// File: rtl/riscv_pkg.sv
// riscv_pkg: datapath-wide defaults shared by the integer register file and its
// read ports, plus the read-source selection used by every read port.
package riscv_pkg;

    localparam int          XLEN_DEF   = 32;
    localparam logic [31:0] RST_PC_DEF = 32'h0000_0000;
    localparam int          NREG_INT   = 32;
    localparam int          NRD_DEF    = 2;

    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_FWD,
        SRC_ARRAY
    } rd_src_e;

    // A hardwired x0 beats a same-cycle write, which in turn beats stored data.
    function automatic rd_src_e pick_src(input logic is_x0, input logic fwd_hit);
        if (is_x0) return SRC_ZERO;
        if (fwd_hit) return SRC_FWD;
        return SRC_ARRAY;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: decode/writeback/fetch side of the register file, bundled
// as one interface. The master drives addresses and write data; the slave returns read data and PC.
interface regfile_mp_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2
);
    logic [NRD-1:0]      re;
    logic [NRD*AW-1:0]   ra;
    logic                we;
    logic [AW-1:0]       wa;
    logic [XLEN-1:0]     wd;
    logic                pc_en;
    logic [XLEN-1:0]     pcnext;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      rd_valid;
    logic [XLEN-1:0]     pc;

    modport master (
        output re, ra, we, wa, wd, pc_en, pcnext,
        input  rd, rd_valid, pc
    );

    modport slave (
        input  re, ra, we, wa, wd, pc_en, pcnext,
        output rd, rd_valid, pc
    );

endinterface

// File: rtl/regfile_rdport.sv
// regfile_rdport: one registered read port. It selects between zero, forwarded
// write data and stored array data, then registers the result.
module regfile_rdport
    import riscv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int AW      = 5,
    parameter bit ZERO_X0 = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            re,
    input  logic [AW-1:0]   ra,
    input  logic            wr_en,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic [XLEN-1:0] arr_data,
    output logic [XLEN-1:0] rd,
    output logic            rd_valid
);

    rd_src_e         src;
    logic [XLEN-1:0] value;

    always_comb begin
        src   = pick_src(ZERO_X0 && (ra == '0), wr_en && (wa == ra));
        value = arr_data;
        unique case (src)
            SRC_ZERO: value = '0;
            SRC_FWD:  value = wd;
            default:  value = arr_data;
        endcase
    end

    // When re is low, rd keeps its last value; only rd_valid reports the missing read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd       <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= re;
            if (re) rd <= value;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: integer register file with NRD registered read ports, one write
// port with write-first forwarding, an optional hardwired x0, and the architectural PC.
module regfile_mp
    import riscv_pkg::*;
#(
    parameter int              XLEN    = XLEN_DEF,
    parameter int              NREG    = NREG_INT,
    parameter int              AW      = $clog2(NREG),
    parameter int              NRD     = NRD_DEF,
    parameter logic [XLEN-1:0] RST_PC  = XLEN'(RST_PC_DEF),
    parameter bit              ZERO_X0 = 1'b1
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);

    logic [XLEN-1:0] regs [NREG];
    logic            wr_en;
    logic [XLEN-1:0] port_rd    [NRD];
    logic            port_valid [NRD];

    assign wr_en = bus.we && !(ZERO_X0 && (bus.wa == '0));

    // The array has no reset so that it maps onto block RAM. A write that arrives
    // on the same edge as reset is dropped so the reset edge leaves no trace.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) regs[bus.wa] <= bus.wd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            bus.pc <= RST_PC;
        else if (bus.pc_en) bus.pc <= bus.pcnext;
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        regfile_rdport #(
            .XLEN    (XLEN),
            .AW      (AW),
            .ZERO_X0 (ZERO_X0)
        ) u_port (
            .clk      (clk),
            .rst      (rst),
            .re       (bus.re[i]),
            .ra       (bus.ra[i*AW +: AW]),
            .wr_en    (wr_en),
            .wa       (bus.wa),
            .wd       (bus.wd),
            .arr_data (regs[bus.ra[i*AW +: AW]]),
            .rd       (port_rd[i]),
            .rd_valid (port_valid[i])
        );
    end

    always_comb begin
        bus.rd       = '0;
        bus.rd_valid = '0;
        for (int i = 0; i < NRD; i++) begin
            bus.rd[i*XLEN +: XLEN] = port_rd[i];
            bus.rd_valid[i]        = port_valid[i];
        end
    end

endmodule
